// File: rtl/direction_input.sv
`timescale 1ns/1ps
// direction_input
//
// Turns four raw push-buttons into the one-hot direction command for the
// 2048 game core. Each button is synchronized, debounced, and a debounced
// 0->1 edge becomes one command. The command is held until the core leaves
// IDLE (acknowledge), then kept for HOLD_CYCLES more cycles. If no
// acknowledge arrives within TIMEOUT_CYCLES, the command is abandoned.
//
// Ports:
//   clk                  system clock
//   rst                  synchronous, active-high reset
//   btn_up/down/left/right  raw asynchronous buttons, active-high
//   game_state[1:0]      core state, 01 = playing/idle (used as acknowledge)
//   direction[3:0]       one-hot command: 0001 up, 0010 down, 0100 left, 1000 right
//   busy                 high whenever the FSM is not ARMED
//   press_dropped        one-cycle pulse when a press is discarded
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// S_WAIT_RELEASE | no command; wait until all debounced buttons are low
// S_ARMED        | ready; the next debounced press is encoded
// S_ISSUE        | command driven, waiting for the core to leave IDLE
// S_HOLD         | acknowledged; command kept for HOLD_CYCLES more cycles

module direction_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [1:0] game_state,
  output logic [3:0] direction,
  output logic       busy,
  output logic       press_dropped
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LIMIT  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]        GS_IDLE   = 2'b01;

  typedef enum logic [1:0] {
    S_WAIT_RELEASE,
    S_ARMED,
    S_ISSUE,
    S_HOLD
  } state_t;

  // Bit order matches the one-hot command encoding.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            db_q, db_d, db_prev_q;
  logic [3:0][DB_W-1:0]  cnt_q, cnt_d;
  logic [3:0]            rise;
  logic [3:0]            press_code;

  state_t              state_q, state_d;
  logic [3:0]          dir_q, dir_d;
  logic                drop_q, drop_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  // Debounce: the level toggles on the DEBOUNCE_CYCLES-th consecutive
  // sample that disagrees with it; any agreeing sample restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] + DB_W'(1) == DB_LIMIT) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign rise = db_q & ~db_prev_q;

  // Simultaneous presses resolve up > down > left > right.
  always_comb begin
    press_code = 4'b0000;
    if (rise[0])      press_code = 4'b0001;
    else if (rise[1]) press_code = 4'b0010;
    else if (rise[2]) press_code = 4'b0100;
    else if (rise[3]) press_code = 4'b1000;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    drop_d  = 1'b0;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_WAIT_RELEASE: begin
        dir_d = 4'b0000;
        if (db_q == 4'b0000) state_d = S_ARMED;
      end
      S_ARMED: begin
        dir_d = 4'b0000;
        if (|rise) begin
          if (game_state == GS_IDLE) begin
            dir_d   = press_code;
            tmo_d   = TMO_LOAD;
            state_d = S_ISSUE;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT_RELEASE;
          end
        end
      end
      S_ISSUE: begin
        // Acknowledge wins over a timeout landing on the same cycle.
        if (game_state != GS_IDLE) begin
          hold_d  = HOLD_LOAD;
          state_d = S_HOLD;
        end else if (tmo_q == '0) begin
          dir_d   = 4'b0000;
          drop_d  = 1'b1;
          state_d = S_WAIT_RELEASE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          dir_d   = 4'b0000;
          state_d = S_WAIT_RELEASE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        dir_d   = 4'b0000;
        state_d = S_WAIT_RELEASE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
      state_q   <= S_WAIT_RELEASE;
      dir_q     <= '0;
      drop_q    <= 1'b0;
      hold_q    <= '0;
      tmo_q     <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      drop_q    <= drop_d;
      hold_q    <= hold_d;
      tmo_q     <= tmo_d;
    end
  end

  assign direction     = dir_q;
  assign press_dropped = drop_q;
  assign busy          = (state_q != S_ARMED);

endmodule

// File: doc/direction_input.md
# direction_input

Front-end that turns four raw push-buttons into the one-hot `direction` command consumed by the 2048 game FSM. Each button is synchronized and debounced, one press is encoded per physical actuation, and the command is held until the game FSM shows it has accepted it. It sits between the board-level button pins and the game core's `direction` input, and watches the core's `game_state` output as its acknowledge.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required before a debounced level changes. Must be ≥1.
- `HOLD_CYCLES`, default 2: extra cycles `direction` stays asserted after the game's acknowledge is first seen. Must be ≥1.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles a command waits for acknowledge before it is abandoned.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw asynchronous buttons, active-high.
- `game_state`  in  2  game core state: 00 not_playing, 01 playing/idle, 10 win, 11 lose.
- `direction`  out  4  one-hot command: 0001 top, 0010 bottom, 0100 left, 1000 right; 0000 means none.
- `busy`  out  1  high whenever the FSM is not in ARMED.
- `press_dropped`  out  1  one-cycle pulse when a press is discarded.

## Operation

- **Synchronizer:** two flip-flops per button. Reset value 0.
- **Debouncer (per button):**
  - Each button has a debounced level `db` (reset 0) and a counter of width $clog2(DEBOUNCE_CYCLES+1) (reset 0).
  - While the synchronized sample equals `db`, the counter clears to 0.
  - While the sample differs from `db`, the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, `db` toggles and the counter clears. It never wraps.
- **Press event:** a 0→1 transition of any `db`. Simultaneous rises resolve by priority up > down > left > right; lower-priority rises that cycle are ignored.
- **FSM** (registered state; `direction` is a registered output):
  - **WAIT_RELEASE:** `direction`=0. Go to ARMED when all four `db` are 0. This is the reset state, so a button held through reset never fires.
  - **ARMED:** `direction`=0.
    - Press event with `game_state`==01: latch the encoded one-hot into `direction` and go to ISSUE.
    - Press event with `game_state`≠01: pulse `press_dropped` and go to WAIT_RELEASE.
  - **ISSUE:** hold `direction`.
    - When `game_state`≠01 is sampled (acknowledge: the core has left IDLE), go to HOLD and load the hold counter with HOLD_CYCLES.
    - If TIMEOUT_CYCLES elapse with `game_state` still 01: clear `direction`, pulse `press_dropped`, go to WAIT_RELEASE.
  - **HOLD:** keep `direction` for HOLD_CYCLES cycles, then clear it and go to WAIT_RELEASE. `game_state` is ignored here. The core's post-move path (MOVE_MERGE, NEW_TILE, CHECK_WIN, CHECK_LOSE) is always longer than HOLD_CYCLES+1, so `direction` is 0 before the core re-enters IDLE and no double move occurs.
- Button activity during ISSUE or HOLD is ignored. Debouncers keep tracking, and WAIT_RELEASE enforces a release before the next command.
- Exactly one bit of `direction` is high, or none. Multi-hot output is illegal.

## Timing

- **Reset:** `rst` high at a clock edge forces, on that edge:
  - all synchronizer flops, `db` levels and counters to 0;
  - `direction`=0000, `busy`=1, `press_dropped`=0;
  - FSM to WAIT_RELEASE.
  
  Reset mid-command drops the command silently, with no `press_dropped` pulse.
- **Press latency:** a clean raw rise sampled at edge t gives a synchronized high at edge t+2 and `db`=1 at edge t+1+DEBOUNCE_CYCLES. `direction` is valid one edge later: t+2+DEBOUNCE_CYCLES.
- **Glitches:** a raw pulse shorter than DEBOUNCE_CYCLES cycles after synchronization produces no event.
- **Acknowledge:** with `game_state`≠01 first sampled at edge a, `direction` is 0 after edge a+HOLD_CYCLES+1. It is nonzero for HOLD_CYCLES+1 cycles counted from the acknowledge cycle.
- **Timeout:** if `direction` is set at edge s and never acknowledged, it clears and `press_dropped` pulses at edge s+TIMEOUT_CYCLES.
- `busy` is combinational from the state register.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=2, TIMEOUT_CYCLES=16.

1. **Basic press:** reset, then `game_state`=01, then a clean `btn_left` rise at edge 10, held → `direction`=0100 from edge 16. Set `game_state`=00 at edge 20 → `direction` is 0100 through edge 22 and 0000 from edge 23. No second command until `btn_left` has been low ≥4 synchronized cycles and is pressed again.
2. **Bounce:** `btn_up` toggling every 2 cycles for 20 cycles, then steady high → exactly one 0001 command, starting 6 edges after the steady high begins.
3. **Priority:** `btn_down` and `btn_right` rise on the same edge → `direction`=0010 only. Releasing `btn_down` while `btn_right` is still held → no 1000 command.
4. **Not playing:** `game_state`=10 and a `btn_up` press → `press_dropped` is a single-cycle pulse and `direction` stays 0000. After release, with `game_state`=01, a new press issues 0001.
5. **Timeout:** `game_state` held at 01 while a `btn_right` press issues 1000 → `direction` clears and `press_dropped` pulses exactly 16 edges after `direction` was set.
6. **Reset:** `btn_up` held through reset, then reset asserted mid-HOLD → `direction`=0000 on the reset edge with no `press_dropped`. No command issues until `btn_up` is released and pressed again.
